// File: rtl/uart_pll_ctrl.sv
// PLL reset/lock sequencer for the UART clock domain: pulses the PLL reset, waits for a
// stable lock with bounded retries, and holds the UART domain in reset until the lock is stable.
module uart_pll_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [3:0] retries
);

  localparam int unsigned CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  // The counter only ever reaches (limit - 1), so clog2 of the largest limit is enough.
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             locked_m;
  logic             locked_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= pll_locked;
      locked_s <= locked_m;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      retries   <= '0;
      lock_lost <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      if (restart) begin
        state   <= RESET_PLL;
        cnt     <= '0;
        retries <= '0;
      end else begin
        unique case (state)
          RESET_PLL: begin
            if (cnt == RST_LAST) begin
              state <= WAIT_LOCK;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          WAIT_LOCK: begin
            if (locked_s) begin
              state <= STABLE;
              cnt   <= '0;
            end else if (cnt == LOCK_LAST) begin
              cnt <= '0;
              if (retries == RETRY_MAX) begin
                state <= FAULT;
              end else begin
                state   <= RESET_PLL;
                retries <= retries + 4'd1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          STABLE: begin
            if (!locked_s) begin
              state <= WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == STABLE_LAST) begin
              state   <= RUN;
              cnt     <= '0;
              retries <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RUN: begin
            if (!locked_s) begin
              state     <= RESET_PLL;
              cnt       <= '0;
              lock_lost <= 1'b1;
            end
          end
          FAULT: begin
            state <= FAULT;
          end
          default: begin
            state <= RESET_PLL;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Decoded straight from the state register so rst_n takes effect without a clock edge.
  always_comb begin
    pll_rst = (state == RESET_PLL) || (state == FAULT);
    ready   = (state == RUN);
    fault   = (state == FAULT);
  end

endmodule

// File: tb/tb_uart_pll_ctrl.sv
// Scoreboard bench for uart_pll_ctrl: expected output vectors are queued with the cycle
// they are due, and a negedge monitor compares them against {pll_rst,ready,fault,lock_lost,retries}.
module tb_uart_pll_ctrl;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [3:0] retries;

  uart_pll_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .ready     (ready),
    .fault     (fault),
    .lock_lost (lock_lost),
    .retries   (retries)
  );

  typedef struct {
    int unsigned at;
    string       tag;
    logic [7:0]  exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_errors;
  logic [7:0]  obs;

  assign obs = {pll_rst, ready, fault, lock_lost, retries};

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mk(input bit pr, input bit rd, input bit ft, input bit ll,
                                    input int unsigned rt);
    return {pr, rd, ft, ll, 4'(rt)};
  endfunction

  task automatic push(input int unsigned at, input string tag, input logic [7:0] exp);
    exp_t e;
    e.at  = at;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  always @(negedge refclk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check(sb[i].tag, obs, sb[i].exp);
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        check({"missed_", sb[i].tag}, obs, sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic wait_drain();
    int unsigned budget;
    budget = 0;
    while (sb.size() > 0 && budget < 200) begin
      @(posedge refclk);
      budget++;
    end
    #1;
    if (sb.size() > 0) begin
      check("drain_timeout", 8'(sb.size()), 8'd0);
      sb.delete();
    end
  endtask

  task automatic lose_and_relock(input bit glitch);
    int unsigned c;
    c = cyc;
    pll_locked = 1'b0;
    push(c + 2, "still_run",    mk(0, 1, 0, 0, 0));
    push(c + 3, "lock_lost",    mk(1, 0, 0, 1, 0));
    push(c + 4, "ll_one_cycle", mk(1, 0, 0, 0, 0));
    push(c + 6, "rerst_last",   mk(1, 0, 0, 0, 0));
    push(c + 7, "rewait",       mk(0, 0, 0, 0, 0));
    wait_cyc(9);
    pll_locked = 1'b1;
    if (!glitch) begin
      push(c + 19, "relock_pre",   mk(0, 0, 0, 0, 0));
      push(c + 20, "relock_ready", mk(0, 1, 0, 0, 0));
    end else begin
      for (int unsigned k = c + 12; k <= c + 27; k++) push(k, "glitch_hold", mk(0, 0, 0, 0, 0));
      push(c + 28, "glitch_ready", mk(0, 1, 0, 0, 0));
      wait_cyc(5);
      pll_locked = 1'b0;
      wait_cyc(3);
      pll_locked = 1'b1;
    end
    wait_drain();
  endtask

  initial begin
    int unsigned b;
    int unsigned r;
    int unsigned s;
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;
    #3;
    check("por", obs, mk(1, 0, 0, 0, 0));

    // Nominal bring-up.
    wait_cyc(1);
    b = cyc;
    rst_n = 1'b1;
    push(b,     "rst_c0",    mk(1, 0, 0, 0, 0));
    push(b + 3, "rst_c3",    mk(1, 0, 0, 0, 0));
    push(b + 4, "wait_lock", mk(0, 0, 0, 0, 0));
    wait_cyc(6);
    pll_locked = 1'b1;
    push(b + 16, "pre_ready", mk(0, 0, 0, 0, 0));
    push(b + 17, "ready",     mk(0, 1, 0, 0, 0));
    wait_drain();

    lose_and_relock(1'b0);
    lose_and_relock(1'b1);

    // Reset in RUN, then lock never arrives.
    rst_n = 1'b0;
    pll_locked = 1'b0;
    #1;
    check("rst_in_run", obs, mk(1, 0, 0, 0, 0));
    wait_cyc(3);
    b = cyc;
    rst_n = 1'b1;
    push(b + 3,  "nl_rst0_end", mk(1, 0, 0, 0, 0));
    push(b + 4,  "nl_wait0",    mk(0, 0, 0, 0, 0));
    push(b + 23, "nl_wait0_end", mk(0, 0, 0, 0, 0));
    push(b + 24, "nl_rst1",     mk(1, 0, 0, 0, 1));
    push(b + 27, "nl_rst1_end", mk(1, 0, 0, 0, 1));
    push(b + 28, "nl_wait1",    mk(0, 0, 0, 0, 1));
    push(b + 47, "nl_wait1_end", mk(0, 0, 0, 0, 1));
    push(b + 48, "nl_rst2",     mk(1, 0, 0, 0, 2));
    push(b + 52, "nl_wait2",    mk(0, 0, 0, 0, 2));
    push(b + 71, "nl_wait2_end", mk(0, 0, 0, 0, 2));
    push(b + 72, "nl_fault",    mk(1, 0, 1, 0, 2));
    wait_cyc(73);
    pll_locked = 1'b1;
    push(b + 80, "fault_hold",  mk(1, 0, 1, 0, 2));
    wait_drain();

    // Restart out of FAULT.
    wait_cyc(1);
    r = cyc;
    restart = 1'b1;
    wait_cyc(1);
    restart = 1'b0;
    push(r + 1,  "restart_fault", mk(1, 0, 0, 0, 0));
    push(r + 4,  "rs_rst_end",    mk(1, 0, 0, 0, 0));
    push(r + 5,  "rs_wait",       mk(0, 0, 0, 0, 0));
    push(r + 13, "rs_pre_ready",  mk(0, 0, 0, 0, 0));
    push(r + 14, "rs_ready",      mk(0, 1, 0, 0, 0));
    wait_drain();

    // Restart while running, then async reset while in STABLE.
    s = cyc;
    restart = 1'b1;
    wait_cyc(1);
    restart = 1'b0;
    push(s + 1, "restart_run", mk(1, 0, 0, 0, 0));
    push(s + 5, "rr_wait",     mk(0, 0, 0, 0, 0));
    wait_cyc(7);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_in_stable", obs, mk(1, 0, 0, 0, 0));
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
